// File: rtl/envelope_demux20.sv
// rtl/envelope_demux20.sv - time-division demultiplexer for per-voice envelope samples
//
// Collects NUM_CH serial beats from a shared sample bus into a shadow buffer
// and commits the complete frame atomically to parallel registered outputs.
//
// Ports:
//   i_clk          rising-edge system clock
//   i_reset        asynchronous active-high reset, clears all state and outputs
//   i_in_data      sample beat (WIDTH bits)
//   i_in_valid     i_in_data carries a beat this cycle
//   i_in_frame     beat is slot 0 of a new frame (only meaningful with i_in_valid)
//   o_ch_data      committed frame, slot n at [n*WIDTH +: WIDTH]
//   o_frame_done   one-cycle pulse on the cycle o_ch_data is updated
//   o_frame_err    one-cycle pulse when a frame start aborts a partial frame
//   o_frame_count  committed frame count, modulo 256
module envelope_demux20 #(
  parameter int NUM_CH = 4,
  parameter int WIDTH  = 20
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic [WIDTH-1:0]        i_in_data,
  input  logic                    i_in_valid,
  input  logic                    i_in_frame,
  output logic [NUM_CH*WIDTH-1:0] o_ch_data,
  output logic                    o_frame_done,
  output logic                    o_frame_err,
  output logic [7:0]              o_frame_count
);

  localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CH - 1);

  typedef enum logic {
    S_SYNC = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t                  r_state;
  logic [IDX_W-1:0]        r_idx;
  logic [NUM_CH*WIDTH-1:0] r_shadow;
  logic [NUM_CH*WIDTH-1:0] w_commit_data;

  // The committing beat goes straight to the output rather than through the
  // shadow, so the frame is published on the same edge its last beat arrives.
  always_comb begin
    w_commit_data = r_shadow;
    w_commit_data[(NUM_CH-1)*WIDTH +: WIDTH] = i_in_data;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state       <= S_SYNC;
      r_idx         <= '0;
      r_shadow      <= '0;
      o_ch_data     <= '0;
      o_frame_done  <= 1'b0;
      o_frame_err   <= 1'b0;
      o_frame_count <= 8'd0;
    end else begin
      o_frame_done <= 1'b0;
      o_frame_err  <= 1'b0;
      if (i_in_valid) begin
        case (r_state)
          S_SYNC: begin
            // Beats without a frame marker are dropped silently while unsynced.
            if (i_in_frame) begin
              if (NUM_CH == 1) begin
                o_ch_data     <= w_commit_data;
                o_frame_done  <= 1'b1;
                o_frame_count <= o_frame_count + 8'd1;
              end else begin
                r_shadow[0 +: WIDTH] <= i_in_data;
                r_idx                <= IDX_W'(1);
                r_state              <= S_RUN;
              end
            end
          end
          S_RUN: begin
            if (i_in_frame) begin
              // Early frame start: abandon the partial frame and restart.
              // Stale shadow slots are harmless, each is rewritten before commit.
              o_frame_err          <= 1'b1;
              r_shadow[0 +: WIDTH] <= i_in_data;
              r_idx                <= IDX_W'(1);
            end else begin
              r_shadow[r_idx*WIDTH +: WIDTH] <= i_in_data;
              if (r_idx == LAST_IDX) begin
                o_ch_data     <= w_commit_data;
                o_frame_done  <= 1'b1;
                o_frame_count <= o_frame_count + 8'd1;
                r_idx         <= '0;
                r_state       <= S_SYNC;
              end else begin
                r_idx <= r_idx + IDX_W'(1);
              end
            end
          end
          default: begin
            r_state <= S_SYNC;
            r_idx   <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_envelope_demux20.sv
// tb/tb_envelope_demux20.sv - self-checking bench for envelope_demux20
module tb_envelope_demux20;

  localparam int NUM_CH = 4;
  localparam int WIDTH  = 20;

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic [WIDTH-1:0]        in_data = '0;
  logic                    in_valid = 1'b0;
  logic                    in_frame = 1'b0;
  logic [NUM_CH*WIDTH-1:0] ch_data;
  logic                    frame_done;
  logic                    frame_err;
  logic [7:0]              frame_count;

  envelope_demux20 #(.NUM_CH(NUM_CH), .WIDTH(WIDTH)) dut (
    .i_clk         (clk),
    .i_reset       (rst),
    .i_in_data     (in_data),
    .i_in_valid    (in_valid),
    .i_in_frame    (in_frame),
    .o_ch_data     (ch_data),
    .o_frame_done  (frame_done),
    .o_frame_err   (frame_err),
    .o_frame_count (frame_count)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model: a frame is the list of beats gathered since the last
  // frame marker; it publishes once the list holds NUM_CH beats.
  logic [WIDTH-1:0]        q[$];
  logic [NUM_CH*WIDTH-1:0] m_ch;
  logic                    m_done;
  logic                    m_err;
  logic [7:0]              m_cnt;

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic model_reset();
    q.delete();
    m_ch   = '0;
    m_done = 1'b0;
    m_err  = 1'b0;
    m_cnt  = 8'd0;
  endtask

  task automatic model_beat(input logic v, input logic f, input logic [WIDTH-1:0] d);
    m_done = 1'b0;
    m_err  = 1'b0;
    if (v) begin
      if (f) begin
        if (q.size() > 0) m_err = 1'b1;
        q.delete();
        q.push_back(d);
      end else if (q.size() > 0) begin
        q.push_back(d);
      end
      if (q.size() == NUM_CH) begin
        for (int i = 0; i < NUM_CH; i++) m_ch[i*WIDTH +: WIDTH] = q[i];
        m_done = 1'b1;
        m_cnt  = m_cnt + 8'd1;
        q.delete();
      end
    end
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".ch_data"}, ch_data, m_ch);
    chk({tag, ".frame_done"}, frame_done, m_done);
    chk({tag, ".frame_err"}, frame_err, m_err);
    chk({tag, ".frame_count"}, frame_count, m_cnt);
  endtask

  // Inputs change #1 after a rising edge; outputs are checked at that same point.
  task automatic step(input string tag, input logic v, input logic f, input logic [WIDTH-1:0] d);
    in_valid = v;
    in_frame = f;
    in_data  = d;
    @(posedge clk);
    #1;
    model_beat(v, f, d);
    check_outputs(tag);
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    in_frame = 1'b0;
    rst = 1'b1;
    #2;
    model_reset();
    check_outputs("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic frame4(input string tag, input logic [WIDTH-1:0] a, b, c, d, input int gap);
    step(tag, 1'b1, 1'b1, a);
    for (int g = 0; g < gap; g++) step(tag, 1'b0, 1'b0, 20'hABCDE);
    step(tag, 1'b1, 1'b0, b);
    for (int g = 0; g < gap; g++) step(tag, 1'b0, 1'b1, 20'h12345);
    step(tag, 1'b1, 1'b0, c);
    for (int g = 0; g < gap; g++) step(tag, 1'b0, 1'b0, 20'h0F0F0);
    step(tag, 1'b1, 1'b0, d);
  endtask

  initial begin
    model_reset();
    #3;
    do_reset();

    // Consecutive frame
    frame4("t1", 20'h00001, 20'h00002, 20'h00003, 20'hFFFFF, 0);
    chk("t1.frame", ch_data, 80'hFFFFF_00003_00002_00001);
    chk("t1.count", frame_count, 8'd1);

    // Same frame with idle gaps; first change a value so the commit is visible
    frame4("t2a", 20'h0AAAA, 20'h0BBBB, 20'h0CCCC, 20'h0DDDD, 0);
    frame4("t2", 20'h00001, 20'h00002, 20'h00003, 20'hFFFFF, 3);
    chk("t2.frame", ch_data, 80'hFFFFF_00003_00002_00001);
    chk("t2.count", frame_count, 8'd3);

    // Early frame marker aborts a partial frame
    step("t3", 1'b1, 1'b1, 20'h11111);
    step("t3", 1'b1, 1'b0, 20'h22222);
    step("t3", 1'b1, 1'b1, 20'h33333);
    chk("t3.err_pulse", frame_err, 1'b1);
    step("t3", 1'b1, 1'b0, 20'h44444);
    step("t3", 1'b1, 1'b0, 20'h55555);
    chk("t3.held", ch_data, 80'hFFFFF_00003_00002_00001);
    step("t3", 1'b1, 1'b0, 20'h66666);
    chk("t3.frame", ch_data, 80'h66666_55555_44444_33333);

    // Unframed beats after reset are dropped
    do_reset();
    step("t4", 1'b1, 1'b0, 20'h77777);
    step("t4", 1'b1, 1'b0, 20'h88888);
    step("t4", 1'b1, 1'b0, 20'h99999);
    frame4("t4", 20'h10001, 20'h20002, 20'h30003, 20'h40004, 0);
    chk("t4.frame", ch_data, 80'h40004_30003_20002_10001);
    chk("t4.count", frame_count, 8'd1);

    // 257 back-to-back frames, count wraps to 1
    do_reset();
    for (int n = 0; n < 257; n++)
      frame4("t5", 20'($urandom), 20'($urandom), 20'($urandom), 20'($urandom), 0);
    chk("t5.count_wrap", frame_count, 8'd1);

    // Reset mid-frame
    step("t6", 1'b1, 1'b1, 20'hDEAD0);
    step("t6", 1'b1, 1'b0, 20'hBEEF1);
    do_reset();
    chk("t6.rst_ch", ch_data, 80'd0);
    frame4("t6", 20'h00A0A, 20'h00B0B, 20'h00C0C, 20'h00D0D, 0);
    chk("t6.frame", ch_data, 80'h00D0D_00C0C_00B0B_00A0A);
    chk("t6.count", frame_count, 8'd1);

    // Random traffic against the model
    for (int n = 0; n < 600; n++)
      step("rnd", ($urandom_range(0, 3) != 0), ($urandom_range(0, 5) == 0), 20'($urandom));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/envelope_demux20.md
# envelope_demux20

Time-division demultiplexer for 20-bit envelope samples. It receives a serial stream of per-voice samples on one shared 20-bit bus and collects each frame of NUM_CH beats into a shadow buffer. On the last beat it commits the whole frame atomically to NUM_CH parallel registered outputs. It is the receiving end of the shared voice bus that the ADSR path drives through its 20-bit selection logic, and feeds the per-voice amplitude stages.

## Interface
- NUM_CH, 4, voices per frame (1..16)
- WIDTH, 20, sample width in bits
- clk  input  1  system clock, rising-edge
- reset  input  1  asynchronous, active-high; clears all state and outputs
- in_data  input  WIDTH  sample beat
- in_valid  input  1  in_data carries a beat this cycle
- in_frame  input  1  qualifies the beat as slot 0 of a new frame; ignored when in_valid=0
- ch_data  output  NUM_CH*WIDTH  committed frame; slot n at bits [n*WIDTH +: WIDTH]
- frame_done  output  1  one-cycle pulse on the cycle ch_data is updated
- frame_err  output  1  one-cycle pulse when an in_frame beat aborts a partial frame
- frame_count  output  8  count of committed frames, wraps 255->0

## Operation
- No backpressure: every beat with in_valid=1 is consumed. Cycles with in_valid=0 are idle and do not advance any state.
- State register: SYNC (waiting for a frame start) and RUN (collecting). Slot index idx has range 0..NUM_CH-1.
- SYNC:
  - A beat with in_frame=0 is discarded with no flag.
  - A beat with in_frame=1 writes shadow[0], sets idx=1 and moves to RUN.
  - If NUM_CH=1, the beat commits immediately instead, and the state stays SYNC.
- RUN, beat with in_frame=0:
  - The beat writes shadow[idx].
  - If idx=NUM_CH-1, commit: ch_data takes the shadow contents with this beat as the last slot. frame_done pulses, frame_count increments, idx resets to 0 and the state returns to SYNC.
  - Otherwise idx increments.
- RUN, beat with in_frame=1 (frame started early):
  - frame_err pulses and the partial shadow contents are abandoned.
  - The beat becomes slot 0 of the new frame, idx=1, and the state stays RUN.
  - ch_data is not modified.
- ch_data changes only on a commit. Between commits it holds the last complete frame, so no output ever shows a mix of two frames.
- frame_done and frame_err cannot assert in the same cycle.
- Arithmetic: frame_count is modulo 256. idx never exceeds NUM_CH-1.

## Timing
- All outputs are registered.
- Last beat of a frame sampled at edge k: ch_data, frame_done=1 and the incremented frame_count are all visible after edge k. frame_done returns to 0 after edge k+1 unless another commit occurs at k+1, which is possible only when NUM_CH=1.
- Back-to-back frames are supported at full rate, one beat per cycle, with no gap cycle required.
- frame_err is asserted for the single cycle following the offending beat's edge.
- Reset values: ch_data=0, frame_done=0, frame_err=0, frame_count=0, state SYNC, idx=0, shadow=0.
- Reset asserted mid-frame discards the partial frame and clears ch_data to 0 immediately (asynchronous). After release, the first accepted beat must carry in_frame=1.

## Test plan
- Reset, then 4 beats 0x00001, 0x00002, 0x00003, 0xFFFFF (first with in_frame=1) on consecutive cycles -> one frame_done pulse after 4th edge; ch_data = {0xFFFFF,0x00003,0x00002,0x00001}; frame_count=1.
- Same frame with in_valid=0 gaps of 3 cycles between beats -> identical ch_data; frame_done exactly once; ch_data unchanged until the last beat.
- Beats 0x11111(frame), 0x22222, then 0x33333(frame), 0x44444, 0x55555, 0x66666 -> frame_err pulse after 3rd beat; then commit {0x66666,0x55555,0x44444,0x33333}; prior ch_data held until then.
- 3 beats with in_frame=0 after reset, then a valid 4-beat frame -> first 3 ignored, no frame_err; single commit of the later frame.
- 257 back-to-back frames at full rate -> frame_done pulses every 4th cycle; frame_count ends at 1 (wrapped).
- Assert reset after beat 2 of a frame, release, send a fresh frame -> all outputs 0 during reset; the commit contains only the new frame's data; frame_count=1.
